// File: rtl/period_timer.sv
// Prescaler (0..TC) driving a modulo-NPER period counter, with a sticky req/ack event flag.
// Define PERIOD_TIMER_OVF_EN to build the sticky overrun flag o_ovf; otherwise o_ovf is tied low.
module period_timer #(
  parameter int unsigned TC   = 29'd399_999_999,
  parameter int unsigned NPER = 60
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_en,
  input  logic        i_clr,
  input  logic        i_ack,
  output logic [28:0] o_cnt,
  output logic        o_tick,
  output logic [5:0]  o_per,
  output logic        o_wrap,
  output logic        o_req,
  output logic        o_ovf
);

  localparam logic [28:0] LP_TC       = 29'(TC);
  localparam logic [5:0]  LP_PER_LAST = 6'(NPER - 1);

  logic [1:0]  r_rel;
  logic [28:0] r_cnt;
  logic        r_tick;
  logic [5:0]  r_per;
  logic        r_wrap;
  logic        r_req;

  logic w_run;
  logic w_term;
  logic w_step;
  logic w_tick_nxt;
  logic w_per_last;

  // Reset asserts asynchronously and releases through two flops; counting
  // begins on the edge that loads the second stage.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rel <= 2'b00;
    end else begin
      r_rel <= {r_rel[0], 1'b1};
    end
  end

  assign w_run      = r_rel[0] | r_rel[1];
  assign w_term     = (r_cnt == LP_TC);
  assign w_step     = w_run & i_en & ~i_clr;
  assign w_tick_nxt = w_step & w_term;
  assign w_per_last = (r_per == LP_PER_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
      r_per  <= '0;
      r_wrap <= 1'b0;
      r_req  <= 1'b0;
    end else if (i_clr) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
      r_per  <= '0;
      r_wrap <= 1'b0;
      r_req  <= 1'b0;
    end else begin
      r_tick <= w_tick_nxt;
      r_wrap <= w_tick_nxt & w_per_last;
      if (w_step) begin
        r_cnt <= w_term ? '0 : r_cnt + 29'd1;
      end
      if (w_tick_nxt) begin
        r_per <= w_per_last ? '0 : r_per + 6'd1;
      end
      // A new event outranks an ack; an ack during the visible tick cycle is ignored.
      if (w_tick_nxt) begin
        r_req <= 1'b1;
      end else if (i_ack && !r_tick) begin
        r_req <= 1'b0;
      end
    end
  end

`ifdef PERIOD_TIMER_OVF_EN
  logic r_ovf;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ovf <= 1'b0;
    end else if (i_clr) begin
      r_ovf <= 1'b0;
    end else if (w_tick_nxt && r_req && !i_ack) begin
      r_ovf <= 1'b1;
    end
  end

  assign o_ovf = r_ovf;
`else
  assign o_ovf = 1'b0;
`endif

  assign o_cnt  = r_cnt;
  assign o_tick = r_tick;
  assign o_per  = r_per;
  assign o_wrap = r_wrap;
  assign o_req  = r_req;

endmodule

// File: doc/period_timer.md
PERIOD_TIMER -- requirements
Module: period_timer

Interface
REQ-001 Parameter TC, default 29'd399_999_999, is the terminal count; the period is TC+1 clk cycles (8 s at 50 MHz).
REQ-002 Parameter NPER, default 60, is the period-counter modulus.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 en  input  1  count enable; prescaler holds its value when en=0.
REQ-006 clr  input  1  synchronous clear of prescaler and period counter; has priority over en.
REQ-007 cnt  output  29  current prescaler value, bits [28:0].
REQ-008 tick  output  1  one-cycle pulse marking prescaler terminal count.
REQ-009 per  output  6  elapsed periods, modulo NPER.
REQ-010 wrap  output  1  one-cycle pulse when per wraps from NPER-1 to 0.
REQ-011 req  output  1  sticky event-pending flag for a slower consumer.
REQ-012 ack  input  1  consumer acknowledge of req.
REQ-013 ovf  output  1  sticky overrun flag (see Configuration).

Function
REQ-014 Prescaler increments by 1 each cycle with en=1 and clr=0.
REQ-015 At cnt==TC with en=1, the next cnt is 0, not TC+1: wrap-around at TC.
REQ-016 tick is registered: it is 1 in the cycle after the edge on which cnt goes from TC to 0, and 0 otherwise.
REQ-017 tick never asserts on consecutive cycles; minimum spacing is TC+1 cycles.
REQ-018 On each tick edge, per increments; at per==NPER-1 it becomes 0 and wrap pulses in the same cycle as tick.
REQ-019 With en=0, cnt, per and req hold their values and tick/wrap are 0; the next en=1 cycle resumes counting from the held cnt.
REQ-020 With clr=1, the next state is cnt=0, per=0, tick=0, wrap=0, req=0, ovf=0, regardless of en or ack.
REQ-021 req sets on the edge that raises tick.
REQ-022 req clears on an edge with ack=1 and no simultaneous tick.
REQ-023 If tick and ack coincide, req stays 1 because the new event wins.
REQ-024 ack with req=0 is ignored.
REQ-025 Terminal detect is a full 29-bit equality against TC; partial-bit matching is forbidden.
REQ-026 Values of TC >= 2^29 are illegal; the bench flags them as an error at elaboration.

Reset
REQ-027 rst_n=0 immediately forces cnt=0, per=0, tick=0, wrap=0, req=0, ovf=0, independent of clk.
REQ-028 Reset deassertion is synchronized internally with a 2-flop release.
REQ-029 The first increment occurs on the second rising clk edge after rst_n rises.
REQ-030 Reset asserted mid-period discards the partial count; after release no tick appears until TC+1 enabled cycles have elapsed.

Configuration
REQ-031 Macro PERIOD_TIMER_OVF_EN defined: ovf sets when tick occurs while req=1 and ack=0.
REQ-032 With PERIOD_TIMER_OVF_EN defined, ovf clears only on reset or clr.
REQ-033 Macro PERIOD_TIMER_OVF_EN undefined: ovf is tied to 0 and no overrun logic is synthesized.
REQ-034 All other behaviour is identical with and without PERIOD_TIMER_OVF_EN.

Verification
REQ-035 Override TC=9, NPER=4, hold en=1 for 50 cycles after reset release -> tick at cycles 10,20,30,40 after first increment; wrap coincides with the 4th tick; per sequence is 1,2,3,0.
REQ-036 Default TC, run 400_000_000 enabled cycles -> exactly one tick; cnt equals 0 in the cycle tick is high.
REQ-037 TC=9, drop en for 5 cycles at cnt=7 -> cnt holds at 7; tick is delayed by exactly 5 cycles.
REQ-038 TC=9, assert ack in the same cycle as tick with req=1 -> req remains 1; ack on the next cycle -> req=0.
REQ-039 TC=9, with PERIOD_TIMER_OVF_EN: never ack across two ticks -> ovf=1 after the second tick and stays set until clr. Without the macro -> ovf stays 0.
REQ-040 TC=9, pulse rst_n low asynchronously at cnt=5, and separately pulse clr at cnt=TC:
- On rst_n low: all outputs are 0 within the same cycle.
- After rst_n release: the first tick follows the REQ-029 delay plus 10 cycles.
- On clr at cnt=TC: no tick is produced.
